fiber_cmd_tx: RTL and testbench

- Downstream neighbour of the command-frame RAM reader.
- Captures one 181-word, 16-bit command frame streamed on frame_valid, and checks its word count and address order.
- Packs the frame into 32-bit beats and sends header, length/sequence, payload and checksum to the fiber transceiver over a valid/ready interface.
- Single-frame buffer: one frame is captured, then transmitted; frames arriving while busy are dropped.

---
 rtl/fiber_cmd_pkg.sv | 32 +++
 rtl/fiber_cmd_buf.sv | 25 ++
 rtl/fiber_cmd_tx.sv | 192 +++++++++++++++++++
 tb/tb_fiber_cmd_tx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fiber_cmd_pkg.sv
// Shared types and constants for the fiber command-frame transmitter.
// Holds the FSM state encoding, framing constants and the CRC-16 word step.
package fiber_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    HDR,
    LEN,
    PAYLOAD,
    CSUM
  } state_e;

  localparam logic [31:0] SYNC_HDR    = 32'hA5A5_1234;
  localparam logic [15:0] TRAILER_TAG = 16'h55AA;
  localparam logic [15:0] CRC16_POLY  = 16'h1021;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;

  // CRC-16-CCITT over one 16-bit word, MSB first, no reflection.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC16_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/fiber_cmd_buf.sv
// Simple dual-port frame buffer bank: one write port, one registered read port.
module fiber_cmd_buf #(
  parameter int AW = 7,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // NOTE: the array and its read register have no reset so the tools can map them onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fiber_cmd_tx.sv
// Captures one command frame, checks count/order, and streams it as 32-bit beats.
// Define FIBER_TX_CRC16_EN to replace the additive checksum with CRC-16-CCITT.
module fiber_cmd_tx
  import fiber_cmd_pkg::*;
#(
  parameter int FRAME_WORDS = 181,
  parameter int BUF_AW      = 8
) (
  input  logic        clk_rd,
  input  logic        FPGA_nRESET,
  input  logic [15:0] frame_in,
  input  logic [9:0]  frame_addr,
  input  logic        frame_valid,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic        frame_drop,
  output logic        frame_err,
  output logic [15:0] seq_cnt
);

  localparam int              PW        = BUF_AW - 1;
  localparam int              PAIRS     = (FRAME_WORDS + 1) / 2;
  localparam logic [9:0]      WORDS_C   = 10'(FRAME_WORDS);
  localparam logic [15:0]     WORDS_16  = 16'(FRAME_WORDS);
  localparam logic [PW-1:0]   LAST_PAIR = PW'(PAIRS - 1);
  localparam bit              ODD_TAIL  = (FRAME_WORDS % 2) == 1;

`ifdef FIBER_TX_CRC16_EN
  localparam logic [15:0] CHK_INIT = CRC16_INIT;
`else
  localparam logic [15:0] CHK_INIT = 16'h0000;
`endif

  function automatic logic [15:0] chk_acc(input logic [15:0] acc, input logic [15:0] w);
`ifdef FIBER_TX_CRC16_EN
    return crc16_word(acc, w);
`else
    return acc + w;
`endif
  endfunction

  state_e        state_q, state_d;
  logic [9:0]    in_cnt_q, in_cnt_d;
  logic          err_q, err_d;
  logic [15:0]   chk_q, chk_d;
  logic [15:0]   seq_q, seq_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          fv_q;
  logic          ign_q, ign_d;
  logic          drop_q, drop_d;
  logic          ferr_q, ferr_d;
  logic          wr_en;
  logic [BUF_AW-1:0] wr_idx;
  logic [15:0]   rd_even, rd_odd;
  logic          xfer;

  // Words are split across two banks (even/odd index) so one read yields a full payload beat.
  assign wr_idx = (state_q == CAPTURE) ? in_cnt_q[BUF_AW-1:0] : '0;

  fiber_cmd_buf #(.AW(PW), .DW(16)) u_buf_even (
    .clk_i   (clk_rd),
    .we_i    (wr_en && !wr_idx[0]),
    .waddr_i (wr_idx[BUF_AW-1:1]),
    .wdata_i (frame_in),
    .raddr_i (rd_ptr_d),
    .rdata_o (rd_even)
  );

  fiber_cmd_buf #(.AW(PW), .DW(16)) u_buf_odd (
    .clk_i   (clk_rd),
    .we_i    (wr_en && wr_idx[0]),
    .waddr_i (wr_idx[BUF_AW-1:1]),
    .wdata_i (frame_in),
    .raddr_i (rd_ptr_d),
    .rdata_o (rd_odd)
  );

  assign xfer = tx_valid && tx_ready;

  // A rising frame_valid outside IDLE drops that frame; its remaining words stay ignored.
  assign drop_d = frame_valid && !fv_q && (state_q != IDLE);
  assign ign_d  = frame_valid && (ign_q || drop_d);

  // The read address looks one beat ahead, so the registered RAM output always
  // holds the pair for rd_ptr_q and beats flow without bubbles.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch behind.
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    err_d    = err_q;
    chk_d    = chk_q;
    seq_d    = seq_q;
    rd_ptr_d = '0;
    wr_en    = 1'b0;
    ferr_d   = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = '0;

    unique case (state_q)
      IDLE: begin
        if (frame_valid && !ign_q) begin
          state_d  = CAPTURE;
          wr_en    = 1'b1;
          in_cnt_d = 10'd1;
          err_d    = (frame_addr != 10'd0);
          chk_d    = chk_acc(CHK_INIT, frame_in);
        end
      end
      CAPTURE: begin
        if (frame_valid) begin
          if (in_cnt_q < WORDS_C) begin
            wr_en    = 1'b1;
            in_cnt_d = in_cnt_q + 10'd1;
            chk_d    = chk_acc(chk_q, frame_in);
          end
          if (in_cnt_q >= WORDS_C || frame_addr != in_cnt_q) err_d = 1'b1;
        end else if (in_cnt_q == WORDS_C && !err_q) begin
          state_d = HDR;
        end else begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_HDR;
        if (xfer) state_d = LEN;
      end
      LEN: begin
        tx_valid = 1'b1;
        tx_data  = {WORDS_16, seq_q};
        if (xfer) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = {rd_even, (ODD_TAIL && rd_ptr_q == LAST_PAIR) ? 16'h0000 : rd_odd};
        rd_ptr_d = rd_ptr_q;
        if (xfer) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == LAST_PAIR) state_d = CSUM;
        end
      end
      CSUM: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = {TRAILER_TAG, chk_q};
        if (xfer) begin
          state_d = IDLE;
          seq_d   = seq_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_rd or negedge FPGA_nRESET) begin
    if (!FPGA_nRESET) begin
      state_q  <= IDLE;
      in_cnt_q <= '0;
      err_q    <= 1'b0;
      chk_q    <= '0;
      seq_q    <= '0;
      rd_ptr_q <= '0;
      fv_q     <= 1'b0;
      ign_q    <= 1'b0;
      drop_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      err_q    <= err_d;
      chk_q    <= chk_d;
      seq_q    <= seq_d;
      rd_ptr_q <= rd_ptr_d;
      fv_q     <= frame_valid;
      ign_q    <= ign_d;
      drop_q   <= drop_d;
      ferr_q   <= ferr_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign frame_drop = drop_q;
  assign frame_err  = ferr_q;
  assign seq_cnt    = seq_q;

endmodule

// File: tb/tb_fiber_cmd_tx.sv
// Directed/randomized bench for fiber_cmd_tx against a frame-level reference model.
module tb_fiber_cmd_tx;

  localparam int FW = 181;
  localparam int NB = 94;

  logic        clk_rd = 1'b0;
  logic        FPGA_nRESET;
  logic [15:0] frame_in;
  logic [9:0]  frame_addr;
  logic        frame_valid;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_last;
  logic        busy;
  logic        frame_drop;
  logic        frame_err;
  logic [15:0] seq_cnt;

  always #5 clk_rd = ~clk_rd;

  fiber_cmd_tx dut (
    .clk_rd      (clk_rd),
    .FPGA_nRESET (FPGA_nRESET),
    .frame_in    (frame_in),
    .frame_addr  (frame_addr),
    .frame_valid (frame_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_last     (tx_last),
    .busy        (busy),
    .frame_drop  (frame_drop),
    .frame_err   (frame_err),
    .seq_cnt     (seq_cnt)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] words [FW];
  logic [32:0] exp_q [$];
  logic [32:0] rx_q  [$];
  int          rx_cyc[$];
  int          cyc = 0;
  int          err_cnt = 0, drop_cnt = 0, vld_cnt = 0, stall_bad = 0, stall_seen = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_beat = '0;
  int          rdy_mode = 1;

  always @(posedge clk_rd) cyc <= cyc + 1;

  // Ready driver: 0 = held low, 1 = held high, 2 = random.
  always begin
    @(posedge clk_rd);
    #1;
    case (rdy_mode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: collects transferred beats, output pulses and stall-hold violations.
  always @(negedge clk_rd) begin
    if (!FPGA_nRESET) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && {tx_valid, tx_last, tx_data} !== {1'b1, prev_beat}) stall_bad <= stall_bad + 1;
      if (tx_valid && tx_ready) begin
        rx_q.push_back({tx_last, tx_data});
        rx_cyc.push_back(cyc);
      end
      if (frame_err)  err_cnt  <= err_cnt + 1;
      if (frame_drop) drop_cnt <= drop_cnt + 1;
      if (tx_valid)   vld_cnt  <= vld_cnt + 1;
      if (tx_valid && !tx_ready) stall_seen <= stall_seen + 1;
      prev_stall <= tx_valid && !tx_ready;
      prev_beat  <= {tx_last, tx_data};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_rd);
    #1;
  endtask

  function automatic logic [32:0] rx_at(input int idx);
    if (idx < rx_q.size()) return rx_q[idx];
    return 'x;
  endfunction

  task automatic fill_fixed();
    words[0] = 16'hABCD;
    for (int i = 1; i < FW; i++) words[i] = 16'h0003;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < FW; i++) words[i] = 16'($urandom);
  endtask

  // Frame-level model: header, length/seq, word pairs (zero-padded), checksum trailer.
  task automatic build_model(input logic [15:0] seq);
    logic [15:0] ck;
    logic        fb;
    exp_q.delete();
    exp_q.push_back({1'b0, 32'hA5A51234});
    exp_q.push_back({1'b0, 16'(FW), seq});
    for (int k = 0; k < FW; k += 2)
      exp_q.push_back({1'b0, words[k], (k + 1 < FW) ? words[k+1] : 16'h0000});
`ifdef FIBER_TX_CRC16_EN
    ck = 16'hFFFF;
    for (int i = 0; i < FW; i++) begin
      for (int b = 15; b >= 0; b--) begin
        fb = ck[15] ^ words[i][b];
        ck = ck << 1;
        if (fb) ck = ck ^ 16'h1021;
      end
    end
`else
    ck = 16'h0000;
    for (int i = 0; i < FW; i++) ck = ck + words[i];
`endif
    exp_q.push_back({1'b1, 16'h55AA, ck});
  endtask

  task automatic send_frame(input int n, input int skip_at);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_rd);
      #1;
      frame_valid = 1'b1;
      frame_in    = words[i];
      frame_addr  = 10'((i >= skip_at) ? i + 1 : i);
    end
    @(posedge clk_rd);
    #1;
    frame_valid = 1'b0;
    frame_in    = '0;
    frame_addr  = '0;
  endtask

  task automatic wait_rx(input int n, input int base, input string tag);
    for (int c = 0; c < 3000 && rx_q.size() < base + n; c++) tick();
    chk(tag, 64'(rx_q.size()), 64'(base + n));
  endtask

  task automatic cmp_frame(input int base, input string tag);
    for (int i = 0; i < NB; i++)
      chk($sformatf("%s_beat%0d", tag, i), 64'(rx_at(base + i)), 64'(exp_q[i]));
  endtask

  initial begin
    int          base, e0, d0, v0, s0, ss0, n_rst;
    logic [32:0] b;

    FPGA_nRESET = 1'b0;
    frame_valid = 1'b0;
    frame_in    = '0;
    frame_addr  = '0;
    repeat (3) tick();
    chk("reset_outputs", 64'({tx_data, tx_valid, tx_last, busy, frame_drop, frame_err, seq_cnt}), 64'd0);
    FPGA_nRESET = 1'b1;
    tick();

    // Fixed frame, ready always high.
    rdy_mode = 1;
    fill_fixed();
    build_model(16'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    base = rx_q.size();
    send_frame(FW, 1000);
    chk("t1_busy_after_capture", 64'(busy), 64'd1);
    wait_rx(NB, base, "t1_beat_count");
    cmp_frame(base, "t1");
    chk("t1_hdr",    64'(rx_at(base)),      {31'd0, 1'b0, 32'hA5A51234});
    chk("t1_len",    64'(rx_at(base + 1)),  {31'd0, 1'b0, 32'h00B50000});
    chk("t1_first",  64'(rx_at(base + 2)),  {31'd0, 1'b0, 32'hABCD0003});
    chk("t1_tail",   64'(rx_at(base + 92)), {31'd0, 1'b0, 32'h00030000});
`ifndef FIBER_TX_CRC16_EN
    chk("t1_csum",   64'(rx_at(base + 93)), {31'd0, 1'b1, 32'h55AAADE9});
`endif
    chk("t1_no_bubbles", 64'(rx_cyc[base + NB - 1] - rx_cyc[base]), 64'(NB - 1));
    tick();
    chk("t1_seq", 64'(seq_cnt), 64'd1);
    chk("t1_busy_done", 64'(busy), 64'd0);

    // Same frame under random backpressure.
    rdy_mode = 2;
    build_model(16'd1);
    s0 = stall_bad; ss0 = stall_seen;
    base = rx_q.size();
    send_frame(FW, 1000);
    wait_rx(NB, base, "t2_beat_count");
    cmp_frame(base, "t2");
    chk("t2_stall_hold", 64'(stall_bad - s0), 64'd0);
    chk("t2_stalls_seen", 64'(stall_seen > ss0), 64'd1);
    tick();
    chk("t2_seq", 64'(seq_cnt), 64'd2);

    // Random words under random backpressure.
    fill_rand();
    build_model(16'd2);
    s0 = stall_bad;
    base = rx_q.size();
    send_frame(FW, 1000);
    wait_rx(NB, base, "t3_beat_count");
    cmp_frame(base, "t3");
    chk("t3_stall_hold", 64'(stall_bad - s0), 64'd0);
    tick();
    chk("t3_seq", 64'(seq_cnt), 64'd3);

    // Short frame: 180 words.
    rdy_mode = 1;
    e0 = err_cnt; v0 = vld_cnt;
    send_frame(FW - 1, 1000);
    repeat (10) tick();
    chk("t4_err_pulse", 64'(err_cnt - e0), 64'd1);
    chk("t4_no_valid",  64'(vld_cnt - v0), 64'd0);
    chk("t4_seq",       64'(seq_cnt), 64'd3);
    chk("t4_busy",      64'(busy), 64'd0);

    // Address skip 50 -> 52.
    e0 = err_cnt; v0 = vld_cnt;
    send_frame(FW, 51);
    repeat (10) tick();
    chk("t5_err_pulse", 64'(err_cnt - e0), 64'd1);
    chk("t5_no_valid",  64'(vld_cnt - v0), 64'd0);
    chk("t5_seq",       64'(seq_cnt), 64'd3);

    // Second frame arrives while the first is stalled in transmit.
    rdy_mode = 0;
    fill_rand();
    build_model(16'd3);
    d0 = drop_cnt; e0 = err_cnt; s0 = stall_bad;
    base = rx_q.size();
    send_frame(FW, 1000);
    for (int c = 0; c < 50 && !tx_valid; c++) tick();
    chk("t6_valid_up", 64'(tx_valid), 64'd1);
    send_frame(FW, 1000);
    repeat (3) tick();
    chk("t6_drop_once", 64'(drop_cnt - d0), 64'd1);
    chk("t6_no_err",    64'(err_cnt - e0), 64'd0);
    chk("t6_held_hdr",  64'({tx_valid, tx_data}), {31'd0, 1'b1, 32'hA5A51234});
    rdy_mode = 1;
    wait_rx(NB, base, "t6_beat_count");
    cmp_frame(base, "t6");
    chk("t6_stall_hold", 64'(stall_bad - s0), 64'd0);
    tick();
    chk("t6_seq", 64'(seq_cnt), 64'd4);

    // Reset during transmit, then a fresh frame.
    fill_rand();
    base = rx_q.size();
    send_frame(FW, 1000);
    wait_rx(40, base, "t7_reach_beat40");
    FPGA_nRESET = 1'b0;
    #1;
    chk("t7_reset_outputs", 64'({tx_data, tx_valid, tx_last, busy, frame_drop, frame_err, seq_cnt}), 64'd0);
    n_rst = rx_q.size();
    repeat (2) tick();
    FPGA_nRESET = 1'b1;
    repeat (5) tick();
    chk("t7_no_tail", 64'(rx_q.size()), 64'(n_rst));
    fill_rand();
    build_model(16'd0);
    base = rx_q.size();
    send_frame(FW, 1000);
    wait_rx(NB, base, "t7_beat_count");
    cmp_frame(base, "t7");
    b = rx_at(base + 1);
    chk("t7_seq_field", 64'(b[15:0]), 64'd0);
    tick();
    chk("t7_seq", 64'(seq_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
